// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM states
// and bit positions of the per-byte error flags.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_PUSH,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a look-ahead head: the oldest entry is presented
// on o_data whenever the FIFO is non-empty, and reads as zero when empty.
module sync_fifo #(
    parameter int Width = 10,
    parameter int Depth = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (AW+1)'(Depth));
    // Full is judged on the pre-pop count, so push-while-full always drops.
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Configurable-format UART receiver with start-bit glitch rejection, per-byte
// parity/framing flags and a receive FIFO drained through valid/ready.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ClkFreq    = 10_000_000,
    parameter int BaudRate   = 115200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_byte,
    output logic [1:0] o_rx_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int ClksPerBit = ClkFreq / BaudRate;
    localparam int HalfBit    = ClksPerBit / 2;
    localparam int CntW       = $clog2(ClksPerBit + 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);

    rx_state_e       state_q;
    logic            rx_meta_q, rx_s_q;
    logic [CntW-1:0] baud_q;
    logic [3:0]      bit_q;
    logic [7:0]      shift_q, shift_in;
    logic            par_err_q, frm_err_q;
    logic            tick, par_x;
    logic [1:0]      err;
    logic            fifo_full, fifo_empty;
    logic [9:0]      fifo_head;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick  = (baud_q == '0);
    assign par_x = (^shift_q) ^ rx_s_q;

    // LSB-first: each sample enters at the top data bit, so the byte ends up
    // right-aligned with zeros above DataBits.
    always_comb begin
        shift_in = {1'b0, shift_q[7:1]};
        shift_in[DataBits-1] = rx_s_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (!tick) baud_q <= baud_q - 1'b1;
            unique case (state_q)
                ST_IDLE: if (!rx_s_q) begin
                    state_q   <= ST_START;
                    baud_q    <= HalfLoad;
                    bit_q     <= '0;
                    shift_q   <= '0;
                    par_err_q <= 1'b0;
                    frm_err_q <= 1'b0;
                end
                ST_START: if (tick) begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DATA;
                        baud_q  <= BitLoad;
                    end
                end
                ST_DATA: if (tick) begin
                    shift_q <= shift_in;
                    baud_q  <= BitLoad;
                    if (bit_q == 4'(DataBits - 1)) begin
                        bit_q   <= '0;
                        state_q <= (ParityMode != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                ST_PARITY: if (tick) begin
                    par_err_q <= (ParityMode == PAR_ODD) ? !par_x : par_x;
                    baud_q    <= BitLoad;
                    state_q   <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    if (!rx_s_q) frm_err_q <= 1'b1;
                    if (bit_q == 4'(StopBits - 1)) begin
                        state_q <= ST_PUSH;
                    end else begin
                        bit_q  <= bit_q + 1'b1;
                        baud_q <= BitLoad;
                    end
                end
                // A framing error usually means a held-low line; wait for idle.
                ST_PUSH:  state_q <= frm_err_q ? ST_BREAK : ST_IDLE;
                ST_BREAK: if (rx_s_q) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err = '0;
        err[ERR_PARITY] = par_err_q;
        err[ERR_FRAME]  = frm_err_q;
    end

    sync_fifo #(
        .Width (10),
        .Depth (FifoDepth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (state_q == ST_PUSH),
        .i_data  ({err, shift_q}),
        .i_pop   (i_rx_ready),
        .o_data  (fifo_head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    assign o_rx_valid = !fifo_empty;
    assign o_rx_byte  = fifo_head[7:0];
    assign o_rx_err   = fifo_head[9:8];
    assign o_overrun  = (state_q == ST_PUSH) && fifo_full;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the next-generation serial front end of the board top level. It adds configurable frame format (data bits, parity, stop bits), per-byte error reporting, glitch rejection on the start bit and a receive FIFO with a valid/ready drain interface. Sits between the `i_uart_rx` pin and the command/data consumer, replacing the fixed 8N1 receiver.

## Interface
- `ClkFreq`, 10_000_000, system clock frequency in Hz.
- `BaudRate`, 115200, line rate in baud.
- `DataBits`, 8, data bits per frame, legal 5..8.
- `ParityMode`, 0, parity mode: 0 none, 1 even, 2 odd.
- `StopBits`, 1, stop bits per frame, legal 1 or 2.
- `FifoDepth`, 16, FIFO entries; power of two, at least 2.

Ports:
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rx`  in  1  asynchronous serial line; idles high.
- `o_rx_valid`  out  1  FIFO head valid.
- `i_rx_ready`  in  1  consumer accepts the head entry.
- `o_rx_byte`  out  8  head data; bits above `DataBits` are 0.
- `o_rx_err`  out  2  head error flags: [0] parity error, [1] framing error.
- `o_overrun`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `o_busy`  out  1  receiver FSM not in IDLE.

## Operation
- `ClksPerBit = ClkFreq/BaudRate`, using integer division (86 at the defaults). `HalfBit = ClksPerBit/2`.
- `i_rx` passes through a 2-flop synchroniser. The FSM uses only the synchronised value `rx_s`. Both flops reset to 1.
- FSM states:
  - IDLE: on `rx_s`=0, go to START and clear the bit counter.
  - START: wait `HalfBit` clocks, then sample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no push.
  - DATA: wait `ClksPerBit`, then sample and shift into the shift register LSB-first. After `DataBits` samples, go to PARITY if `ParityMode`≠0, else to STOP.
  - PARITY: wait `ClksPerBit`, then sample. Error if the XOR of the data bits and the parity bit is 1 (even) or 0 (odd).
  - STOP: wait `ClksPerBit`, then sample; repeat `StopBits` times. Any stop sample of 0 sets the framing error.
  - PUSH: one cycle. Write {err, data} to the FIFO, then go to IDLE if there is no framing error, else to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Errored frames are still pushed, with their flags set.
- FIFO behaviour:
  - Push in PUSH when not full.
  - If the FIFO is full in PUSH, the frame is discarded, `o_overrun` pulses and the FIFO contents are unchanged.
  - Pop when `o_rx_valid && i_rx_ready`.
  - A simultaneous push and pop while full is not a special case: the full test uses the pre-pop count, so the frame is dropped and flagged as overrun.
  - Pointers are `$clog2(FifoDepth)` bits wide and wrap naturally. The count is one bit wider.
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `o_rx_valid`=0, `o_rx_byte`=0, `o_rx_err`=0, `o_overrun`=0, `o_busy`=0.
- Reset asserted mid-frame aborts the frame: no push, and the FIFO is emptied.

## Timing
- The synchroniser adds 2 cycles from the pin edge to `rx_s`.
- The push occurs the cycle after the final stop-bit sample.
- `o_rx_valid` rises the cycle after the push (FIFO head registered), so data is visible 1 cycle after PUSH.
- `o_rx_byte` and `o_rx_err` are stable while `o_rx_valid`=1 and `i_rx_ready`=0.
- Pop updates the head on the next edge. With ≥2 entries, back-to-back pops sustain 1 entry per cycle.
- `o_overrun` is high for exactly the PUSH cycle of the dropped frame.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - state encoding for the FSM;
  - error-bit index constants `ERR_PARITY`/`ERR_FRAME`.
- One sub-module, `sync_fifo`:
  - parameters: width, depth;
  - signals: push/data-in, pop, head data, empty, full;
  - synchronous active-high reset.
- The FSM, baud counter and shift register live in `uart_rx_fifo`.

## Test plan
- Defaults (8N1, 86 clk/bit): send 0xA5, then 0x3C back-to-back, `i_rx_ready`=1 → two entries, 0xA5 then 0x3C, with `o_rx_err`=0.
- Set `DataBits`=7, `ParityMode`=1 (even), `StopBits`=2. Send 0x41 with correct parity, then 0x41 with the parity bit flipped → `o_rx_byte`=0x41 for both; `o_rx_err` is 0b00, then 0b01.
- Send a frame with its stop bit driven 0, then hold the line low for 20 bit times → exactly one entry with `o_rx_err`=0b10, no further pushes until the line returns high, then the next valid frame is received normally.
- Drive a 30-clock low glitch on an idle line → no push and `o_busy` back to 0 within `HalfBit`+3 cycles.
- `FifoDepth`=4, `i_rx_ready`=0, send 5 frames 0x01..0x05:
  - 4 entries are held, and `o_overrun` pulses once on the 5th frame;
  - draining then yields 0x01..0x04.
- Assert `i_rst` for 1 cycle during DATA of a frame → all outputs reset. The remainder of the interrupted frame yields no entry (a falling data-bit edge may be taken as a start and must then fail START or finish with a framing error). The next clean frame is received correctly.
